// File: rtl/opcg_scan_ctrl.sv
// TCK-domain OPCG test-side initiator: a JTAG TDR selects app/scan mode and
// requests capture bursts, each sequenced as a four-phase tscan_exe/texe_done handshake.
module opcg_scan_ctrl #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic tck,
  input  logic trst,
  input  logic ir_sel,
  input  logic capture_dr,
  input  logic shift_dr,
  input  logic update_dr,
  input  logic tdi,
  output logic tdo,
  input  logic texe_done,
  output logic tapp_active,
  output logic tscan_exe,
  output logic busy,
  output logic err
);

  localparam int DR_W = CNT_W + 2;

  typedef enum logic [1:0] {IDLE, REQ, REL, ABORT} state_t;

  state_t            state, state_nxt;
  logic [DR_W-1:0]   dr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [CNT_W-1:0]  dr_cnt;
  logic [TO_W-1:0]   tocnt;
  logic              upd, start, timeout;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  assign upd     = ir_sel & update_dr;
  assign dr_cnt  = dr[DR_W-1:2];
  // A burst request with app_req set is dropped: bursts only make sense in scan mode.
  assign start   = upd & ~busy & ~dr[0] & (dr_cnt != '0);
  assign timeout = (tocnt == TO_W'(TIMEOUT));
  assign tdo     = dr[0];

  // Handshake sequencing; a texe_done edge takes priority over a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = REQ;
          count_nxt = dr_cnt;
        end
      end
      REQ: begin
        if (texe_done) begin
          state_nxt = REL;
          count_nxt = sat_dec(count);
        end else if (timeout) begin
          state_nxt = ABORT;
        end
      end
      REL: begin
        if (!texe_done) state_nxt = (count == '0) ? IDLE : REQ;
        else if (timeout) state_nxt = ABORT;
      end
      ABORT: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, phase timer and status
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state       <= IDLE;
      count       <= '0;
      tocnt       <= '0;
      tscan_exe   <= 1'b0;
      busy        <= 1'b0;
      tapp_active <= 1'b1;
      err         <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      tscan_exe <= (state_nxt == REQ);
      busy      <= (state_nxt != IDLE);
      if (state_nxt != state)                tocnt <= '0;
      else if (state == REQ || state == REL) tocnt <= tocnt + 1'b1;
      if (upd && !busy) tapp_active <= dr[0];
      if (state == ABORT)     err <= 1'b1;
      else if (upd && dr[1])  err <= 1'b0;
    end
  end

  // Test data register
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      dr <= '0;
    end else if (ir_sel) begin
      if (capture_dr)    dr <= {count, err, tapp_active};
      else if (shift_dr) dr <= {tdi, dr[DR_W-1:1]};
    end
  end

endmodule
